// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ascon_pkg
// Description : Shared Ascon constants: block width, crypt status-byte bit
//               indices and the result-FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ascon_pkg;

    localparam int ASCON_BLK_W  = 128;

    // Bit positions inside the crypt status byte
    localparam int ST_BUSY      = 0;
    localparam int ST_RD_CORE   = 1;
    localparam int ST_CT_VALID  = 2;
    localparam int ST_TAG_READY = 3;
    localparam int ST_DONE      = 4;

    // One result-FIFO entry: tag marker above the block data
    typedef struct packed {
        logic                   is_tag;
        logic [ASCON_BLK_W-1:0] data;
    } ascon_entry_t;

endpackage
`default_nettype wire

// File: rtl/ascon_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ascon_result_fifo
// Description : First-word-fall-through buffer for ciphertext blocks and tags
//               emitted by the Ascon core, drained by the register interface.
//               Also holds the sticky completion flag shown as 'done'.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_result_fifo
    import ascon_pkg::*;
#(
    parameter int pDEPTH = 16,
    parameter int pWIDTH = ASCON_BLK_W,
    parameter int pCNT_W = $clog2(pDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic              wr_valid,
    input  logic [pWIDTH-1:0] wr_data,
    input  logic              wr_is_tag,
    input  logic              core_done,
    output logic              wr_ready,
    input  logic              rd_pop,
    output logic [pWIDTH-1:0] rd_data,
    output logic              rd_is_tag,
    output logic [pCNT_W-1:0] count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              done
);

    localparam int              PTR_W     = $clog2(pDEPTH);
    localparam logic [pCNT_W-1:0] DEPTH_CNT = pCNT_W'(pDEPTH);

    // Storage: {is_tag, data}; contents are never reset, only pointers are
    logic [pWIDTH:0]     mem_q [pDEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [pCNT_W-1:0]   count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                done_q, done_d;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [pWIDTH:0]     w_head;

    assign w_full  = (count_q == DEPTH_CNT);
    assign w_empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push alongside a pop. Pop legality looks only at the pre-edge count.
    assign w_push  = !clear && wr_valid && (!w_full || rd_pop);
    assign w_pop   = !clear && rd_pop && !w_empty;

    assign w_head    = mem_q[rd_ptr_q];
    assign rd_data   = w_empty ? '0   : w_head[pWIDTH-1:0];
    assign rd_is_tag = w_empty ? 1'b0 : w_head[pWIDTH];

    assign count     = count_q;
    assign empty     = w_empty;
    assign full      = w_full;
    assign wr_ready  = !w_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign done      = done_q;

    // Next-state for pointers, occupancy, sticky flags and done
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        done_d      = done_q;

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            done_d      = 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + pCNT_W'(1);
                2'b01:   count_d = count_q - pCNT_W'(1);
                default: count_d = count_q;
            endcase
            if (wr_valid && w_full && !rd_pop) begin
                overflow_d = 1'b1;
            end
            if (rd_pop && w_empty) begin
                underflow_d = 1'b1;
            end
            // core_done wins over a coincident start
            if (core_done) begin
                done_d = 1'b1;
            end else if (start) begin
                done_d = 1'b0;
            end
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
        end
    end

    // Entry array write port
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {wr_is_tag, wr_data};
        end
    end

endmodule
`default_nettype wire
